axi4lite_regbank: RTL and testbench
===================================

// Module: axi4lite_regbank
// PURPOSE
//  Parametrised AXI4-Lite slave register bank: NUM_REGS read/write control registers
//  with per-register reset values, WSTRB byte enables, AW/W accepted in any order,
//  B/R backpressure and SLVERR on out-of-range addresses. Sits behind the system
//  interconnect; register contents drive downstream logic through reg_q.
// PARAMETERS
//  ADDR_W    6   AXI address width (byte address)
//  DATA_W    32  data width, 32 or 64; STRB_W = DATA_W/8
//  NUM_REGS  8   number of registers, 1..2**(ADDR_W-log2(STRB_W))
//  RST_VAL   0   NUM_REGS*DATA_W flat vector; reg i resets to RST_VAL[i*DATA_W +: DATA_W]
// PORTS
//  clk      in   1                 clock
//  reset    in   1                 synchronous, active-high
//  awaddr   in   ADDR_W            write address
//  awprot   in   3                 ignored
//  awvalid  in   1 / awready out 1 write address handshake
//  wdata    in   DATA_W            write data
//  wstrb    in   STRB_W            byte enables
//  wvalid   in   1 / wready  out 1 write data handshake
//  bresp    out  2                 00 OKAY, 10 SLVERR
//  bvalid   out  1 / bready  in  1 write response handshake
//  araddr   in   ADDR_W            read address
//  arprot   in   3                 ignored
//  arvalid  in   1 / arready out 1 read address handshake
//  rdata    out  DATA_W            read data
//  rresp    out  2                 00 OKAY, 10 SLVERR
//  rvalid   out  1 / rready  in  1 read data handshake
//  reg_q    out  NUM_REGS*DATA_W   current register contents, reg i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Reset: regs <= RST_VAL; awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=00;
//    rdata=0; write FSM WR_IDLE, read FSM RD_IDLE. Reset mid-transaction drops it silently.
//  - Index = addr[ADDR_W-1:log2(STRB_W)]; low address bits ignored. Index>=NUM_REGS -> SLVERR.
//  - Write FSM: WR_IDLE -(AW only)-> WR_HAVE_AW; -(W only)-> WR_HAVE_W; -(both)-> WR_RESP;
//    WR_HAVE_AW -(W)-> WR_RESP; WR_HAVE_W -(AW)-> WR_RESP; WR_RESP -(bready)-> WR_IDLE.
//  - awready=1 only in WR_IDLE/WR_HAVE_W; wready=1 only in WR_IDLE/WR_HAVE_AW.
//  - Commit on the edge completing the AW+W pair: bytes with wstrb[b]=1 updated, others kept;
//    bvalid rises same edge, bresp set; reg_q shows new value after that edge.
//  - bvalid/bresp held stable until bready; no new AW/W accepted while bvalid=1.
//  - Out-of-range write: no register changes, bresp=10. wstrb=0: no change, bresp=00.
//  - Read FSM: RD_IDLE (arready=1) -(arvalid)-> RD_RESP (arready=0, rvalid=1)
//    -(rready)-> RD_IDLE. rdata/rresp captured at AR edge, held until rready.
//  - Out-of-range read: rdata=0, rresp=10.
//  - Read and write channels independent. AR handshake on the commit edge of a write
//    to the same register returns the OLD value.
//  - Back-to-back: next AW/W accepted the cycle after bvalid&bready; same for AR after rready.
// CONFIGURATION
//  AXIL_REGBANK_WR_PULSE_EN defined: extra output wr_pulse[NUM_REGS-1:0], one-cycle high
//    on reg i the cycle after an in-range commit to reg i (also when wstrb=0); 0 in reset.
//  Not defined: port absent, no extra logic; all other behaviour identical.
// TESTING
//  1 Reset, NUM_REGS=8, RST_VAL reg0=32'h12345678: read 0x00 -> rdata 12345678, rresp 00.
//  2 AW 0x04 at T, W 32'hDEADBEEF at T+3, bready=0 for 4 cycles -> awready=0 T+1..,
//    bvalid held, bresp 00; reg_q[63:32]=DEADBEEF after W edge.
//  3 Reg1=DEADBEEF, write 0x04 data 0 wstrb 4'b0101 -> reg1=DE00BE00, bresp 00.
//  4 Write 0x20 (idx 8) -> bresp 10, reg_q unchanged; read 0x3C -> rdata 0, rresp 10.
//  5 W before AW, simultaneous AR on same reg at commit edge -> read old value, write lands.
//  6 Reset asserted while bvalid=1 and rvalid=1 -> both 0 next edge, regs=RST_VAL;
//    with AXIL_REGBANK_WR_PULSE_EN, write 0x08 -> wr_pulse=8'b0000_0100 for exactly one cycle.

Source files
------------

// File: rtl/axi4lite_regbank.sv
// axi4lite_regbank: AXI4-Lite register bank with byte strobes, AW/W in any order and SLVERR on out-of-range index.
// Define AXIL_REGBANK_WR_PULSE_EN to add the wr_pulse[NUM_REGS-1:0] commit-pulse output.
module axi4lite_regbank #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int NUM_REGS = 8,
   parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_W-1:0]          awaddr,
   input  logic [2:0]                 awprot,
   input  logic                       awvalid,
   output logic                       awready,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [DATA_W/8-1:0]        wstrb,
   input  logic                       wvalid,
   output logic                       wready,
   output logic [1:0]                 bresp,
   output logic                       bvalid,
   input  logic                       bready,
   input  logic [ADDR_W-1:0]          araddr,
   input  logic [2:0]                 arprot,
   input  logic                       arvalid,
   output logic                       arready,
   output logic [DATA_W-1:0]          rdata,
   output logic [1:0]                 rresp,
   output logic                       rvalid,
   input  logic                       rready,
   output logic [NUM_REGS*DATA_W-1:0] reg_q
`ifdef AXIL_REGBANK_WR_PULSE_EN
   ,
   output logic [NUM_REGS-1:0]        wr_pulse
`endif
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LSB = $clog2(STRB_W);
   localparam int IDX_W = ADDR_W - LSB;
   localparam logic [IDX_W:0] NREG = (IDX_W + 1)'(NUM_REGS);
   localparam logic [1:0] WR_IDLE = 2'd0, WR_HAVE_AW = 2'd1, WR_HAVE_W = 2'd2, WR_RESP = 2'd3;
   localparam logic [0:0] RD_IDLE = 1'b0, RD_RESP = 1'b1;

   logic [1:0]        wr_state, wr_next;
   logic [0:0]        rd_state;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [IDX_W-1:0]  aw_idx_q, w_idx, r_idx;
   logic [DATA_W-1:0] wdata_q, w_data, rd_val;
   logic [STRB_W-1:0] wstrb_q, w_strb;
   logic              aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
   logic              unused;

   assign unused = ^{awprot, arprot, awaddr[LSB-1:0], araddr[LSB-1:0]};
   assign awready = wr_state == WR_IDLE || wr_state == WR_HAVE_W;
   assign wready = wr_state == WR_IDLE || wr_state == WR_HAVE_AW;
   assign bvalid = wr_state == WR_RESP;
   assign arready = rd_state == RD_IDLE;
   assign rvalid = rd_state == RD_RESP;
   assign aw_hs = awvalid && awready;
   assign w_hs = wvalid && wready;
   assign ar_hs = arvalid && arready;
   // The half of the pair arriving on the commit edge is taken straight from the bus
   assign w_idx = aw_hs ? awaddr[ADDR_W-1:LSB] : aw_idx_q;
   assign w_data = w_hs ? wdata : wdata_q;
   assign w_strb = w_hs ? wstrb : wstrb_q;
   assign r_idx = araddr[ADDR_W-1:LSB];
   assign w_ok = {1'b0, w_idx} < NREG;
   assign r_ok = {1'b0, r_idx} < NREG;
   assign wr_next = wr_state == WR_RESP ? (bready ? WR_IDLE : WR_RESP)
                  : (aw_hs || wr_state == WR_HAVE_AW) && (w_hs || wr_state == WR_HAVE_W) ? WR_RESP
                  : aw_hs ? WR_HAVE_AW : w_hs ? WR_HAVE_W : wr_state;
   assign commit = wr_next == WR_RESP && wr_state != WR_RESP;

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (r_idx == IDX_W'(i)) rd_val = regs[i];
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
      assign reg_q[i*DATA_W +: DATA_W] = regs[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
         bresp <= 2'b00;
         rresp <= 2'b00;
         rdata <= '0;
         aw_idx_q <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL[i*DATA_W +: DATA_W];
      end else begin
         wr_state <= wr_next;
         if (aw_hs) aw_idx_q <= awaddr[ADDR_W-1:LSB];
         if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (commit) bresp <= w_ok ? 2'b00 : 2'b10;
         for (int i = 0; i < NUM_REGS; i++)
            for (int b = 0; b < STRB_W; b++)
               if (commit && w_idx == IDX_W'(i) && w_strb[b]) regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
         if (ar_hs) begin
            rdata <= rd_val;
            rresp <= r_ok ? 2'b00 : 2'b10;
            rd_state <= RD_RESP;
         end else if (rready) begin
            rd_state <= RD_IDLE;
         end
      end
   end

`ifdef AXIL_REGBANK_WR_PULSE_EN
   always_ff @(posedge clk)
      for (int i = 0; i < NUM_REGS; i++) wr_pulse[i] <= !reset && commit && w_idx == IDX_W'(i);
`endif
endmodule

// File: tb/tb_axi4lite_regbank.sv
// tb_axi4lite_regbank: randomized self-checking bench for axi4lite_regbank against an array model.
module tb_axi4lite_regbank;
   localparam logic [255:0] RST = {32'hA5A50007, 32'h00000006, 32'hFFFF0005, 32'h00000004,
                                   32'hCAFE0003, 32'h00000002, 32'hBEEF0001, 32'h12345678};
   logic        clk = 0, reset = 1;
   logic [5:0]  awaddr = 0, araddr = 0;
   logic [2:0]  awprot = 0, arprot = 0;
   logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [31:0] wdata = 0, rdata;
   logic [3:0]  wstrb = 0;
   logic [1:0]  bresp, rresp;
   logic [255:0] reg_q;
`ifdef AXIL_REGBANK_WR_PULSE_EN
   logic [7:0]  wr_pulse;
`endif
   logic [31:0] mdl [8];
   int checks = 0, failures = 0;

   axi4lite_regbank #(.ADDR_W(6), .DATA_W(32), .NUM_REGS(8), .RST_VAL(RST)) dut (
      .clk(clk), .reset(reset),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .reg_q(reg_q)
`ifdef AXIL_REGBANK_WR_PULSE_EN
      , .wr_pulse(wr_pulse)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] exp_q();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = mdl[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mdl[i] = RST[i*32 +: 32];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int c = 0;
      int idx = int'(a[5:2]);
      logic [1:0] er = idx < 8 ? 2'b00 : 2'b10;
      while (!(aw_done && w_done) && c < 40) begin
         awaddr = a; wdata = d; wstrb = s;
         awvalid = !aw_done && c >= aw_dly;
         wvalid = !w_done && c >= w_dly;
         aw_hs = awvalid && awready;
         w_hs = wvalid && wready;
         tick();
         c++;
         aw_done |= aw_hs;
         w_done |= w_hs;
         if (!(aw_done && w_done)) begin
            checks++;
            if (awready !== !aw_done || wready !== !w_done || bvalid !== 1'b0) begin
               failures++;
               $display("FAIL wr_wait: awready=%b wready=%b bvalid=%b expected %b %b 0", awready, wready, bvalid, !aw_done, !w_done);
            end
         end
      end
      awvalid = 0; wvalid = 0;
      if (c >= 40) begin
         failures++;
         $display("FAIL wr_timeout: addr=%h handshakes not completed", a);
         return;
      end
      if (idx < 8) for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      checks++;
      if (bvalid !== 1'b1 || bresp !== er || reg_q !== exp_q()) begin
         failures++;
         $display("FAIL wr_commit: addr=%h bvalid=%b bresp=%b reg_q=%h expected 1 %b %h", a, bvalid, bresp, reg_q, er, exp_q());
      end
`ifdef AXIL_REGBANK_WR_PULSE_EN
      checks++;
      if (wr_pulse !== (idx < 8 ? 8'(1 << idx) : 8'h00)) begin
         failures++;
         $display("FAIL wr_pulse: got %b expected %b", wr_pulse, idx < 8 ? 8'(1 << idx) : 8'h00);
      end
`endif
      for (int i = 0; i < b_dly; i++) begin
         tick();
         checks++;
         if (bvalid !== 1'b1 || bresp !== er || awready !== 1'b0 || wready !== 1'b0) begin
            failures++;
            $display("FAIL b_hold: bvalid=%b bresp=%b awready=%b wready=%b expected 1 %b 0 0", bvalid, bresp, awready, wready, er);
         end
      end
      bready = 1;
      tick();
      bready = 0;
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
         failures++;
         $display("FAIL b_done: bvalid=%b awready=%b wready=%b expected 0 1 1", bvalid, awready, wready);
      end
`ifdef AXIL_REGBANK_WR_PULSE_EN
      checks++;
      if (wr_pulse !== 8'h00) begin
         failures++;
         $display("FAIL wr_pulse_clear: got %b expected 00000000", wr_pulse);
      end
`endif
   endtask

   task automatic do_read(input logic [5:0] a, input int ar_dly, input int r_dly);
      int c = 0;
      int idx = int'(a[5:2]);
      bit hs = 0;
      logic [31:0] ed = idx < 8 ? mdl[idx] : 32'h0;
      logic [1:0] er = idx < 8 ? 2'b00 : 2'b10;
      while (!hs && c < 40) begin
         araddr = a;
         arvalid = c >= ar_dly;
         hs = arvalid && arready;
         tick();
         c++;
      end
      arvalid = 0;
      if (!hs) begin
         failures++;
         $display("FAIL rd_timeout: addr=%h no AR handshake", a);
         return;
      end
      for (int i = 0; i <= r_dly; i++) begin
         checks++;
         if (rvalid !== 1'b1 || rdata !== ed || rresp !== er || arready !== 1'b0) begin
            failures++;
            $display("FAIL rd_data: addr=%h rvalid=%b rdata=%h rresp=%b arready=%b expected 1 %h %b 0", a, rvalid, rdata, rresp, arready, ed, er);
         end
         if (i < r_dly) tick();
      end
      rready = 1;
      tick();
      rready = 0;
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         failures++;
         $display("FAIL rd_done: rvalid=%b arready=%b expected 0 1", rvalid, arready);
      end
   endtask

   task automatic test_reset();
      reset = 1;
      tick(); tick();
      reset = 0;
      model_reset();
      checks++;
      if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1 || bvalid !== 1'b0 || rvalid !== 1'b0 ||
          bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0 || reg_q !== RST) begin
         failures++;
         $display("FAIL reset: aw/w/ar ready=%b%b%b b/r valid=%b%b rdata=%h reg_q=%h expected 111 00 0 %h",
                  awready, wready, arready, bvalid, rvalid, rdata, reg_q, RST);
      end
      do_read(6'h00, 0, 0);
   endtask

   task automatic test_aw_first();
      do_write(6'h04, 32'hDEADBEEF, 4'hF, 0, 3, 4);
      checks++;
      if (reg_q[63:32] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL aw_first_reg1: got %h expected deadbeef", reg_q[63:32]);
      end
   endtask

   task automatic test_strobe();
      do_write(6'h04, 32'h0, 4'b0101, 1, 0, 0);
      checks++;
      if (reg_q[63:32] !== 32'hDE00BE00) begin
         failures++;
         $display("FAIL strobe_reg1: got %h expected de00be00", reg_q[63:32]);
      end
      do_write(6'h08, 32'hFFFFFFFF, 4'b0000, 0, 0, 1);
      do_read(6'h04, 1, 2);
   endtask

   task automatic test_slverr();
      do_write(6'h20, 32'h11111111, 4'hF, 0, 0, 0);
      do_write(6'h3F, 32'h22222222, 4'hF, 2, 1, 0);
      do_read(6'h3C, 0, 1);
      do_read(6'h21, 0, 0);
   endtask

   task automatic test_w_first_ar_collide();
      logic [31:0] old = mdl[3], d = $urandom;
      wdata = d; wstrb = 4'hF; wvalid = 1;
      tick();
      wvalid = 0;
      checks++;
      if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
         failures++;
         $display("FAIL have_w: awready=%b wready=%b bvalid=%b expected 1 0 0", awready, wready, bvalid);
      end
      awaddr = 6'h0C; araddr = 6'h0C; awvalid = 1; arvalid = 1;
      tick();
      awvalid = 0; arvalid = 0;
      mdl[3] = d;
      checks++;
      if (rvalid !== 1'b1 || rdata !== old || rresp !== 2'b00 || bvalid !== 1'b1 || bresp !== 2'b00 || reg_q !== exp_q()) begin
         failures++;
         $display("FAIL collide: rvalid=%b rdata=%h bvalid=%b bresp=%b reg_q=%h expected 1 %h 1 00 %h",
                  rvalid, rdata, bvalid, bresp, reg_q, old, exp_q());
      end
      bready = 1; rready = 1;
      tick();
      bready = 0; rready = 0;
      checks++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
         failures++;
         $display("FAIL collide_done: bvalid=%b rvalid=%b expected 0 0", bvalid, rvalid);
      end
      do_read(6'h0C, 0, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic [5:0] a = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         else
            do_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
      end
   endtask

   task automatic test_reset_mid();
      awaddr = 6'h14; wdata = 32'h55AA55AA; wstrb = 4'hF; araddr = 6'h14;
      awvalid = 1; wvalid = 1; arvalid = 1;
      tick();
      awvalid = 0; wvalid = 0; arvalid = 0;
      checks++;
      if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
         failures++;
         $display("FAIL mid_setup: bvalid=%b rvalid=%b expected 1 1", bvalid, rvalid);
      end
      reset = 1;
      tick();
      reset = 0;
      model_reset();
      checks++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1 ||
          rdata !== 32'h0 || reg_q !== RST) begin
         failures++;
         $display("FAIL mid_reset: bvalid=%b rvalid=%b ready=%b%b%b rdata=%h reg_q=%h expected 0 0 111 0 %h",
                  bvalid, rvalid, awready, wready, arready, rdata, reg_q, RST);
      end
      do_write(6'h08, 32'h0BADF00D, 4'hF, 0, 0, 0);
      do_read(6'h08, 0, 0);
   endtask

   initial begin
      test_reset();
      test_aw_first();
      test_strobe();
      test_slverr();
      test_w_first_ar_collide();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
